btn_bank_ctrl: RTL

//  Parametrised front-panel button controller for the bicycle helper: N_BTN toggle/momentary

---
 rtl/btn_bank_ctrl.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/btn_bank_ctrl.sv
// btn_bank_ctrl: front-panel button bank for the bicycle helper.
// N_BTN independent toggle/momentary channels plus an up/down pair that steps
// a saturating rate level. Every raw input is synchronised, polarity-normalised
// and debounced locally. Optional auto-repeat on the up/down pair is enabled
// with the BTN_AUTOREPEAT_EN macro.
module btn_bank_ctrl #(
  parameter int unsigned      N_BTN      = 4,
  parameter logic [N_BTN-1:0] ACT_LOW    = N_BTN'(4'b0100),
  parameter logic [N_BTN-1:0] MOMENTARY  = '0,
  parameter int unsigned      DB_CYCLES  = 1000000,
  parameter int unsigned      RATE_W     = 2,
  parameter int unsigned      RATE_MAX   = 3,
  parameter int unsigned      REP_DELAY  = 25000000,
  parameter int unsigned      REP_PERIOD = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_BTN-1:0]  btn_in,
  input  logic              up_btn,
  input  logic              down_btn,
  output logic [N_BTN-1:0]  state,
  output logic [N_BTN-1:0]  tick,
  output logic [RATE_W-1:0] rate,
  output logic              rate_lim
);

  // Channels 0..N_BTN-1 are general buttons, N_BTN is up, N_BTN+1 is down.
  localparam int unsigned    N_IN  = N_BTN + 2;
  localparam int unsigned    CNT_W = $clog2(DB_CYCLES);
  localparam logic [N_IN-1:0] POL  = {2'b00, ACT_LOW};
  localparam int unsigned    UP    = N_BTN;
  localparam int unsigned    DN    = N_BTN + 1;

  // Reject configurations the datapath cannot represent.
  if (N_BTN < 1 || N_BTN > 16 || DB_CYCLES < 2 || RATE_MAX < 1 ||
      RATE_MAX > ((1 << RATE_W) - 1) || REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_cfg
    $error("btn_bank_ctrl: illegal parameter combination");
  end

  logic [N_IN-1:0]   raw_c;
  logic [N_IN-1:0]   norm_c;
  logic [N_IN-1:0]   press_c;
  logic [N_IN-1:0]   sync1_q, sync2_q;
  logic [N_IN-1:0]   stable_q, prev_q;
  logic [CNT_W-1:0]  cnt_q [N_IN];
  logic [N_BTN-1:0]  tick_q, state_q;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic              rate_lim_q;
  logic              up_step_c, dn_step_c;

  assign raw_c   = {down_btn, up_btn, btn_in};
  assign norm_c  = sync2_q ^ POL;
  assign press_c = stable_q & ~prev_q;

  // Synchronise raw inputs; reset to the idle raw level so nothing looks pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= POL;
      sync2_q <= POL;
    end else begin
      sync1_q <= raw_c;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: a new level must persist DB_CYCLES evaluations before it is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      stable_q <= '0;
      prev_q   <= '0;
      for (int i = 0; i < int'(N_IN); i++) cnt_q[i] <= '0;
    end else begin
      prev_q <= stable_q;
      for (int i = 0; i < int'(N_IN); i++) begin
        if (norm_c[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_W'(DB_CYCLES - 1)) begin
          stable_q[i] <= norm_c[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Channel outputs: tick on press, then toggle (or follow the debounced level).
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q  <= '0;
      state_q <= '0;
    end else begin
      tick_q <= press_c[N_BTN-1:0];
      for (int i = 0; i < int'(N_BTN); i++) begin
        if (MOMENTARY[i]) begin
          state_q[i] <= stable_q[i];
        end else if (tick_q[i]) begin
          state_q[i] <= ~state_q[i];
        end
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] rep_cnt_q [2];
  logic [1:0]       rep_first_q;
  logic [1:0]       rep_step_c;
  logic [1:0]       held_c;
  logic [1:0]       pair_press_c;

  assign held_c       = stable_q[DN:UP];
  assign pair_press_c = press_c[DN:UP];

  // Repeat step fires once after REP_DELAY of holding, then every REP_PERIOD.
  always_comb begin
    rep_step_c = '0;
    for (int j = 0; j < 2; j++) begin
      if (held_c[j] && !pair_press_c[j]) begin
        if (rep_first_q[j]) rep_step_c[j] = (rep_cnt_q[j] == REP_W'(REP_DELAY - 1));
        else                rep_step_c[j] = (rep_cnt_q[j] == REP_W'(REP_PERIOD - 1));
      end
    end
  end

  // Repeat timers restart on every press and clear on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      rep_first_q <= '1;
      for (int j = 0; j < 2; j++) rep_cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (!held_c[j] || pair_press_c[j]) begin
          rep_cnt_q[j]   <= '0;
          rep_first_q[j] <= 1'b1;
        end else if (rep_step_c[j]) begin
          rep_cnt_q[j]   <= '0;
          rep_first_q[j] <= 1'b0;
        end else begin
          rep_cnt_q[j] <= rep_cnt_q[j] + REP_W'(1);
        end
      end
    end
  end

  assign up_step_c = press_c[UP] | rep_step_c[0];
  assign dn_step_c = press_c[DN] | rep_step_c[1];
`else
  assign up_step_c = press_c[UP];
  assign dn_step_c = press_c[DN];
`endif

  // Next rate: saturating step, simultaneous up and down cancel.
  always_comb begin
    rate_d = rate_q;
    if (up_step_c && !dn_step_c && rate_q != RATE_W'(RATE_MAX)) begin
      rate_d = rate_q + RATE_W'(1);
    end else if (dn_step_c && !up_step_c && rate_q != '0) begin
      rate_d = rate_q - RATE_W'(1);
    end
  end

  // Rate and its limit flag update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      rate_q     <= '0;
      rate_lim_q <= 1'b1;
    end else begin
      rate_q     <= rate_d;
      rate_lim_q <= (rate_d == '0) || (rate_d == RATE_W'(RATE_MAX));
    end
  end

  assign state    = state_q;
  assign tick     = tick_q;
  assign rate     = rate_q;
  assign rate_lim = rate_lim_q;

endmodule
